// File: rtl/vx_barrier_table_pkg.sv
// Shared types for the warp barrier tracker: sizing constants,
// barrier request bundle and barrier table entry.
package vx_barrier_table_pkg;

    localparam int NUM_WARPS    = 4;
    localparam int NUM_BARRIERS = 4;
    localparam int NW_BITS      = $clog2(NUM_WARPS);
    localparam int NB_BITS      = $clog2(NUM_BARRIERS);
    localparam int NW_W         = (NW_BITS == 0) ? 1 : NW_BITS;
    localparam int NB_W         = (NB_BITS == 0) ? 1 : NB_BITS;

    typedef logic [NW_W-1:0]      wid_t;
    typedef logic [NB_W-1:0]      bid_t;
    typedef logic [NUM_WARPS-1:0] wmask_t;

    typedef struct packed {
        logic valid;
        wid_t wid;
        bid_t id;
        wid_t size_m1;
    } bar_req_t;

    typedef struct packed {
        logic   active;
        wmask_t mask;
        wid_t   count;
        wid_t   size_m1;
    } bar_entry_t;

    function automatic wmask_t wid_onehot(input wid_t w);
        return wmask_t'(1) << w;
    endfunction

endpackage

// File: rtl/vx_barrier_table_if.sv
// Barrier request / release handshake bundle.
// master: GPU unit + scheduler side; slave: the barrier table.
interface vx_barrier_table_if;
    import vx_barrier_table_pkg::*;

    logic   bar_valid;
    logic   bar_ready;
    wid_t   bar_wid;
    bid_t   bar_id;
    wid_t   bar_size_m1;
    logic   release_valid;
    logic   release_ready;
    wmask_t release_mask;

    modport master (
        output bar_valid,
        output bar_wid,
        output bar_id,
        output bar_size_m1,
        output release_ready,
        input  bar_ready,
        input  release_valid,
        input  release_mask
    );

    modport slave (
        input  bar_valid,
        input  bar_wid,
        input  bar_id,
        input  bar_size_m1,
        input  release_ready,
        output bar_ready,
        output release_valid,
        output release_mask
    );

endinterface

// File: rtl/vx_barrier_table_rel_buf.sv
// Depth-1 elastic output register for the release mask.
// Ports: in_valid/in_ready/in_data upstream, out_valid/out_ready/out_data downstream.
module vx_barrier_table_rel_buf #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // A new entry may overwrite the slot in the same cycle it drains.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end
    end

endmodule

// File: rtl/vx_barrier_table.sv
// Warp barrier tracker: records arrivals per barrier, holds warps stalled
// and emits a registered release mask when the last participant arrives.
// Ports: clk, reset, bar_if (slave handshake bundle), stalled_mask, dup_error.
module vx_barrier_table
    import vx_barrier_table_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    vx_barrier_table_if.slave bar_if,
    output wmask_t            stalled_mask,
    output logic              dup_error
);

    bar_req_t   req;
    bar_entry_t tbl   [NUM_BARRIERS];
    bar_entry_t tbl_n [NUM_BARRIERS];
    bar_entry_t cur;
    wmask_t     wid_oh;
    wmask_t     rel_mask_n;
    wmask_t     held;
    logic       fire;
    logic       rel_fire;
    logic       dup_set;

    assign req = '{
        valid:   bar_if.bar_valid,
        wid:     bar_if.bar_wid,
        id:      bar_if.bar_id,
        size_m1: bar_if.bar_size_m1
    };

    assign fire   = req.valid && bar_if.bar_ready;
    assign cur    = tbl[req.id];
    assign wid_oh = wid_onehot(req.wid);

    always_comb begin
        tbl_n      = tbl;
        rel_fire   = 1'b0;
        rel_mask_n = '0;
        dup_set    = 1'b0;
        if (fire) begin
            if (!cur.active) begin
                if (req.size_m1 == '0) begin
                    // single-warp barrier never occupies the table
                    rel_fire   = 1'b1;
                    rel_mask_n = wid_oh;
                end else begin
                    tbl_n[req.id] = '{
                        active:  1'b1,
                        mask:    wid_oh,
                        count:   wid_t'(1),
                        size_m1: req.size_m1
                    };
                end
            end else if ((cur.mask & wid_oh) != '0) begin
                dup_set = 1'b1;
            end else if (cur.count == cur.size_m1) begin
                rel_fire      = 1'b1;
                rel_mask_n    = cur.mask | wid_oh;
                tbl_n[req.id] = '0;
            end else begin
                tbl_n[req.id].mask  = cur.mask | wid_oh;
                tbl_n[req.id].count = cur.count + wid_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BARRIERS; i++) begin
                tbl[i] <= '0;
            end
            dup_error <= 1'b0;
        end else begin
            tbl <= tbl_n;
            if (dup_set) begin
                dup_error <= 1'b1;
            end
        end
    end

    vx_barrier_table_rel_buf #(
        .WIDTH (NUM_WARPS)
    ) rel_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rel_fire),
        .in_ready  (bar_if.bar_ready),
        .in_data   (rel_mask_n),
        .out_valid (bar_if.release_valid),
        .out_ready (bar_if.release_ready),
        .out_data  (bar_if.release_mask)
    );

    always_comb begin
        held = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            held = held | tbl[i].mask;
        end
    end

    // released warps stay stalled until the scheduler takes the mask
    assign stalled_mask = held
        | (bar_if.release_valid ? bar_if.release_mask : '0);

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && req.valid) begin
            assert (int'(req.id) < NUM_BARRIERS)
            else $error("bar_id out of range");
        end
    end
`endif

endmodule
